l0_loader: RTL

//  Streams activation/weight vectors from the activation SRAM into the L0 input FIFO of the corelet.
//  One SRAM word = one L0 row vector (row lanes of bw bits).

---
 rtl/l0_loader_pkg.sv | 10 +
 rtl/l0_loader_skid.sv | 46 ++++
 rtl/l0_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/l0_loader_pkg.sv
// l0_loader_pkg: shared FSM encoding and sizing constants for the L0 loader.
//   state_e    : IDLE -> READ -> DRAIN -> DONE -> IDLE
//   SKID_DEPTH : entries in the return-data skid buffer
//   SRAM_LAT   : SRAM read latency in cycles (data valid one cycle after cen low)
package l0_loader_pkg;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;
    localparam int SKID_DEPTH = 2;
    localparam int SRAM_LAT   = 1;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
endpackage

// File: rtl/l0_loader_skid.sv
// l0_loader_skid: 2-entry FIFO that parks SRAM return data while L0 is full.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write data_i at the tail
//   pop_i         : drop the head entry
//   head_o        : oldest entry
//   count_o       : number of stored entries
// Simultaneous push and pop leaves the count unchanged. The caller never
// pushes when full or pops when empty.
module l0_loader_skid
    import l0_loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PW = $clog2(SKID_DEPTH);
    logic [W-1:0]     mem_q [SKID_DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        wr_d    = wr_q + PW'(push_i);
        rd_d    = rd_q + PW'(pop_i);
        cnt_d   = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        head_o  = mem_q[rd_q];
        count_o = cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/l0_loader.sv
// l0_loader: streams len SRAM words starting at base_addr into the corelet L0 FIFO.
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   start_i, base_addr_i, len_i : transfer request, latched only when idle
//   busy_o, done_o           : transfer in progress / 1-cycle completion pulse
//   sram_cen_o, sram_wen_o, sram_addr_o, sram_dout_i : read-only SRAM port
//   l0_wr_o, l0_in_o, l0_full_i : L0 write port with back-pressure
//   stall_cnt_o              : only with L0_LOADER_STALL_CNT_EN; cycles stalled on l0_full
// Optional feature macro: L0_LOADER_STALL_CNT_EN.
module l0_loader
    import l0_loader_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int BW     = 4,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11
) (
`ifdef L0_LOADER_STALL_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sram_cen_o,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [BW*ROW-1:0] sram_dout_i,
    output logic              l0_wr_o,
    output logic [BW*ROW-1:0] l0_in_o,
    input  logic              l0_full_i
);
    localparam int DW = BW * ROW;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d, written_q, written_d;
    logic              inflight_q, inflight_d;
    logic              issue, pending, push, pop, accept;
    logic [DW-1:0]     head;
    logic [CNT_W-1:0]  cnt;
    l0_loader_skid #(.W(DW)) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (sram_dout_i),
        .head_o  (head),
        .count_o (cnt)
    );
    always_comb begin
        accept      = (state_q == S_IDLE) && start_i;
        pending     = (cnt != '0) || inflight_q;
        // Counting in-flight reads against skid space means every return has a slot.
        issue       = (state_q == S_READ) && (issued_q != len_q) &&
                      ((cnt + CNT_W'(inflight_q)) < CNT_W'(SKID_DEPTH));
        l0_wr_o     = !l0_full_i && pending;
        pop         = l0_wr_o && (cnt != '0);
        // Returning data bypasses the skid only when nothing older is waiting.
        push        = inflight_q && !(l0_wr_o && (cnt == '0));
        l0_in_o     = (cnt != '0) ? head : inflight_q ? sram_dout_i : '0;
        sram_cen_o  = !issue;
        sram_wen_o  = 1'b1;
        sram_addr_o = base_q + ADDR_W'(issued_q);
        busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
        done_o      = (state_q == S_DONE);
        inflight_d  = issue;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q + LEN_W'(issue);
        written_d   = written_q + LEN_W'(l0_wr_o);
        state_d     = state_q;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                base_d    = base_addr_i;
                len_d     = len_i;
                issued_d  = '0;
                written_d = '0;
                state_d   = (len_i == '0) ? S_DONE : S_READ;
            end
            S_READ:  state_d = (issued_d == len_q) ? S_DRAIN : S_READ;
            S_DRAIN: state_d = (written_d == len_q) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            inflight_q <= inflight_d;
        end
    end
`ifdef L0_LOADER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    always_comb begin
        stall_d     = accept ? '0 :
                      (busy_o && pending && l0_full_i && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        stall_cnt_o = stall_q;
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) stall_q <= '0;
        else           stall_q <= stall_d;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule
